// File: rtl/uart.sv
// Full-duplex 8N1 UART: valid/ready parallel side, tx/rx serial pins.
// Bit time is CLK_FREQ/BAUD_RATE clock cycles (integer-truncated).
// Optional build macro UART_FRAME_ERR_EN adds the rx_frame_err level output.
module uart #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
`ifdef UART_FRAME_ERR_EN
    output logic                  rx_frame_err,
`endif
    input  logic                  rx,
    output logic                  tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t             tx_state_r, tx_state_n_s;
    logic [CNT_W-1:0]      tx_cnt_r, tx_cnt_n_s;
    logic [BIT_W-1:0]      tx_bit_r, tx_bit_n_s;
    logic [DATA_WIDTH-1:0] tx_data_r, tx_data_n_s;
    logic                  tx_r, tx_n_s;
    logic                  tx_ready_r, tx_ready_n_s;
    logic                  tx_accept_s;

    // TX state register and registered serial/handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= '0;
            tx_data_r  <= '0;
            tx_r       <= 1'b1;
            tx_ready_r <= 1'b0;
        end else begin
            tx_state_r <= tx_state_n_s;
            tx_cnt_r   <= tx_cnt_n_s;
            tx_bit_r   <= tx_bit_n_s;
            tx_data_r  <= tx_data_n_s;
            tx_r       <= tx_n_s;
            tx_ready_r <= tx_ready_n_s;
        end
    end

    // TX next state: accept a word in IDLE, then walk start/data/stop bit times
    always_comb begin
        tx_state_n_s = tx_state_r;
        tx_cnt_n_s   = tx_cnt_r;
        tx_bit_n_s   = tx_bit_r;
        tx_accept_s  = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                tx_cnt_n_s = '0;
                tx_bit_n_s = '0;
                if (tx_valid && tx_ready_r && ena) begin
                    tx_accept_s  = 1'b1;
                    tx_state_n_s = TX_START;
                end else begin
                    tx_state_n_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_n_s   = '0;
                    tx_bit_n_s   = '0;
                    tx_state_n_s = TX_DATA;
                end else begin
                    tx_cnt_n_s = tx_cnt_r + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_n_s = '0;
                    if (tx_bit_r == BIT_LAST) begin
                        tx_bit_n_s   = '0;
                        tx_state_n_s = TX_STOP;
                    end else begin
                        tx_bit_n_s = tx_bit_r + BIT_W'(1);
                    end
                end else begin
                    tx_cnt_n_s = tx_cnt_r + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == CNT_LAST) begin
                    tx_cnt_n_s   = '0;
                    tx_state_n_s = TX_IDLE;
                end else begin
                    tx_cnt_n_s = tx_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                tx_cnt_n_s   = '0;
                tx_bit_n_s   = '0;
                tx_state_n_s = TX_IDLE;
            end
        endcase
    end

    // TX outputs decoded from the next state so tx/tx_ready align with the state
    always_comb begin
        tx_data_n_s  = tx_accept_s ? tx_data : tx_data_r;
        tx_ready_n_s = 1'b0;
        case (tx_state_n_s)
            TX_IDLE: begin
                tx_n_s       = 1'b1;
                tx_ready_n_s = ena;
            end
            TX_START: tx_n_s = 1'b0;
            TX_DATA:  tx_n_s = tx_data_r[tx_bit_n_s];
            TX_STOP:  tx_n_s = 1'b1;
            default:  tx_n_s = 1'b1;
        endcase
    end

    assign tx       = tx_r;
    assign tx_ready = tx_ready_r;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  rx_meta_r, rx_sync_r;
    rx_state_t             rx_state_r, rx_state_n_s;
    logic [CNT_W-1:0]      rx_cnt_r, rx_cnt_n_s;
    logic [BIT_W-1:0]      rx_bit_r, rx_bit_n_s;
    logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_n_s;
    logic [DATA_WIDTH-1:0] rx_data_r, rx_data_n_s;
    logic                  rx_valid_r, rx_valid_n_s;
    logic                  rx_wait_r, rx_wait_n_s;
    logic                  rx_start_det_s, rx_stop_ok_s, rx_stop_bad_s;
    logic                  rx_ferr_r, rx_ferr_n_s;

    // Two-flop synchroniser for the asynchronous serial input (idles high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX state register and registered word/flag outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= '0;
            rx_shift_r <= '0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            rx_wait_r  <= 1'b0;
            rx_ferr_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n_s;
            rx_cnt_r   <= rx_cnt_n_s;
            rx_bit_r   <= rx_bit_n_s;
            rx_shift_r <= rx_shift_n_s;
            rx_data_r  <= rx_data_n_s;
            rx_valid_r <= rx_valid_n_s;
            rx_wait_r  <= rx_wait_n_s;
            rx_ferr_r  <= rx_ferr_n_s;
        end
    end

    // RX next state: detect start, confirm at half bit, sample mid-bit, check stop
    always_comb begin
        rx_state_n_s   = rx_state_r;
        rx_cnt_n_s     = rx_cnt_r;
        rx_bit_n_s     = rx_bit_r;
        rx_shift_n_s   = rx_shift_r;
        rx_wait_n_s    = rx_wait_r;
        rx_start_det_s = 1'b0;
        rx_stop_ok_s   = 1'b0;
        rx_stop_bad_s  = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                rx_cnt_n_s  = '0;
                rx_bit_n_s  = '0;
                rx_wait_n_s = 1'b0;
                if (ena && !rx_sync_r) begin
                    rx_start_det_s = 1'b1;
                    rx_state_n_s   = RX_START;
                end else begin
                    rx_state_n_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == CNT_HALF) begin
                    rx_cnt_n_s = '0;
                    // A line already back high at mid start bit is a glitch
                    if (!rx_sync_r) begin
                        rx_state_n_s = RX_DATA;
                    end else begin
                        rx_state_n_s = RX_IDLE;
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_n_s   = '0;
                    rx_shift_n_s = {rx_sync_r, rx_shift_r[DATA_WIDTH-1:1]};
                    if (rx_bit_r == BIT_LAST) begin
                        rx_bit_n_s   = '0;
                        rx_state_n_s = RX_STOP;
                    end else begin
                        rx_bit_n_s = rx_bit_r + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_wait_r) begin
                    // Framing error: hold here until the line idles high again
                    if (rx_sync_r) begin
                        rx_wait_n_s  = 1'b0;
                        rx_state_n_s = RX_IDLE;
                    end else begin
                        rx_state_n_s = RX_STOP;
                    end
                end else if (rx_cnt_r == CNT_LAST) begin
                    rx_cnt_n_s = '0;
                    if (rx_sync_r) begin
                        rx_stop_ok_s = 1'b1;
                        rx_state_n_s = RX_IDLE;
                    end else begin
                        rx_stop_bad_s = 1'b1;
                        rx_wait_n_s   = 1'b1;
                    end
                end else begin
                    rx_cnt_n_s = rx_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                rx_cnt_n_s   = '0;
                rx_bit_n_s   = '0;
                rx_wait_n_s  = 1'b0;
                rx_state_n_s = RX_IDLE;
            end
        endcase
    end

    // RX outputs: levels cleared at start detect, set by the stop-bit verdict
    always_comb begin
        rx_valid_n_s = rx_valid_r;
        rx_data_n_s  = rx_data_r;
        rx_ferr_n_s  = rx_ferr_r;
        if (rx_start_det_s) begin
            rx_valid_n_s = 1'b0;
            rx_ferr_n_s  = 1'b0;
        end else if (rx_stop_ok_s) begin
            rx_valid_n_s = 1'b1;
            rx_data_n_s  = rx_shift_r;
        end else if (rx_stop_bad_s) begin
            rx_ferr_n_s = 1'b1;
        end else begin
            rx_valid_n_s = rx_valid_r;
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;

`ifdef UART_FRAME_ERR_EN
    assign rx_frame_err = rx_ferr_r;
`else
    // Framing errors are dropped silently in this build
    logic unused_ferr_s;
    assign unused_ferr_s = rx_ferr_r;
`endif

endmodule

// File: tb/tb_uart.sv
// Scoreboard bench for uart: expected rx words are queued as stimulus is
// issued and a monitor pops/compares on every rising edge of rx_valid.
// The DUT runs at 16 clocks per bit to keep the full 0x00..0xFF sweep short.
module tb_uart;

    localparam int DW   = 8;
    localparam int BAUD = 115200;
    localparam int CLKF = 115200 * 16;
    localparam int CPB  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ena = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          tx;
    logic          rx_line;
    logic          rx_drv = 1'b1;
    logic          loop_en = 1'b1;
`ifdef UART_FRAME_ERR_EN
    logic          rx_frame_err;
`endif

    int            n_checks = 0;
    int            n_fail = 0;
    int            n_frames = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    logic          mon_prev = 1'b0;

    assign rx_line = loop_en ? tx : rx_drv;

    uart #(.DATA_WIDTH(DW), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`ifdef UART_FRAME_ERR_EN
        .rx_frame_err (rx_frame_err),
`endif
        .rx       (rx_line),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 2000) begin
            tick();
            k++;
        end
        check("tx_ready_wait", tx_ready, 1);
    endtask

    task automatic send_serial(input logic [DW-1:0] v, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < DW; i++) begin
            rx_drv = v[i];
            repeat (CPB) tick();
        end
        rx_drv = stop_bit;
        repeat (CPB) tick();
        rx_drv = 1'b1;
        repeat (2 * CPB) tick();
    endtask

    // Monitor: every new rx_valid level must match the oldest queued word
    always @(negedge clk) begin
        if (!reset && rx_valid && !mon_prev) begin
            n_frames++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected_frame: got 0x%0h, expected no frame", rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_data", rx_data, mon_exp);
            end
        end
        mon_prev = rx_valid;
    end

    // Watchdog so the run always ends
    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish, expected finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_bits;
        int         t;
        int         low;
        int         busy;
        int         frames_before;
        logic       rose;

        a5_bits = 10'b11_0100_1010;

        // Reset values
        ena = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        reset = 1'b0;
        tick();
        check("idle_tx_ready", tx_ready, 1);
        check("idle_tx", tx, 1);
        check("idle_rx_valid", rx_valid, 0);

        // 0xA5 loopback, tx_valid held for 5 cycles
        tx_data = 8'hA5;
        exp_q.push_back(8'hA5);
        tx_valid = 1'b1;
        tick();
        t = 0;
        low = 0;
        rose = 1'b0;
        while (!rose && t < 400) begin
            if (tx_ready) begin
                rose = 1'b1;
                check("a5_ready_low_cycles", low, 10 * CPB);
                check("a5_rx_valid_at_ready", rx_valid, 1);
                check("a5_rx_data_at_ready", rx_data, 8'hA5);
            end else begin
                low++;
                if ((t % CPB) == CPB / 2 && (t / CPB) < 10)
                    check($sformatf("a5_tx_bit%0d", t / CPB), tx, a5_bits[t / CPB]);
            end
            if (t == 4) tx_valid = 1'b0;
            tick();
            t++;
        end
        check("a5_ready_rose", rose, 1);
        repeat (3 * CPB) tick();
        check("a5_single_frame_tx", tx, 1);
        check("a5_single_frame_cnt", n_frames, 1);

        // Sweep of every byte value, back to back
        for (int v = 0; v < 256; v++) begin
            wait_ready();
            tx_data = v[7:0];
            exp_q.push_back(v[7:0]);
            tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
        end
        wait_ready();
        check("sweep_drained", exp_q.size(), 0);
        check("sweep_frames", n_frames, 257);

        // Glitch shorter than half a bit on a directly driven line
        loop_en = 1'b0;
        repeat (4) tick();
        rx_drv = 1'b0;
        repeat (5) tick();
        rx_drv = 1'b1;
        repeat (2 * CPB) tick();
        check("glitch_rx_valid", rx_valid, 0);
        check("glitch_rx_data", rx_data, 8'hFF);
        exp_q.push_back(8'h5A);
        send_serial(8'h5A, 1'b1);
        check("post_glitch_frames", n_frames, 258);

        // Framing error: stop bit sampled low
        send_serial(8'h3C, 1'b0);
        check("ferr_rx_valid", rx_valid, 0);
        check("ferr_rx_data", rx_data, 8'h5A);
`ifdef UART_FRAME_ERR_EN
        check("ferr_flag_set", rx_frame_err, 1);
`endif
        exp_q.push_back(8'h96);
        send_serial(8'h96, 1'b1);
        check("post_ferr_rx_valid", rx_valid, 1);
`ifdef UART_FRAME_ERR_EN
        check("ferr_flag_clear", rx_frame_err, 0);
`endif

        // ena low blocks accepts; raising it starts the frame within 2 cycles
        loop_en = 1'b1;
        ena = 1'b0;
        tick();
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        busy = 0;
        repeat (40) begin
            tick();
            if (tx !== 1'b1 || tx_ready !== 1'b0) busy++;
        end
        check("ena_low_blocked", busy, 0);
        exp_q.push_back(8'hC3);
        ena = 1'b1;
        tick();
        tick();
        check("ena_rise_start_bit", tx, 0);
        tx_valid = 1'b0;
        wait_ready();

        // ena dropped mid-frame: frame completes, tx_ready stays low
        tx_data = 8'h3E;
        exp_q.push_back(8'h3E);
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (3 * CPB) tick();
        ena = 1'b0;
        repeat (9 * CPB) tick();
        check("ena_mid_ready_low", tx_ready, 0);
        check("ena_mid_tx_idle", tx, 1);
        check("ena_mid_frames", n_frames, 261);
        ena = 1'b1;
        wait_ready();

        // Reset mid-frame abandons the frame
        frames_before = n_frames;
        tx_data = 8'h77;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (3 * CPB) tick();
        reset = 1'b1;
        tick();
        check("midrst_tx", tx, 1);
        check("midrst_tx_ready", tx_ready, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 0);
        reset = 1'b0;
        repeat (12 * CPB) tick();
        check("midrst_no_frame", n_frames, frames_before);
        check("midrst_tx_ready_back", tx_ready, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
